// File: rtl/uart_echo_ctrl.sv
// rtl/uart_echo_ctrl.sv - UART echo/response sequencer with receive FIFO and paced reply framing
//
// Ports:
//   Uart_CLK      in   UART bit-rate clock
//   Sys_RST       in   asynchronous active-low reset
//   Rx_Data       in   received byte, valid at the Rx_Rdsig falling edge
//   Rx_Rdsig      in   receiver data-valid level; byte complete on its falling edge
//   Rx_DataError  in   receiver parity error flag
//   Rx_FrameError in   receiver stop-bit error flag
//   Tx_Idle       in   transmitter ready for a new byte
//   Tx_Data       out  byte presented to the transmitter, held between strobes
//   Tx_Wrsig      out  one-cycle write strobe to the transmitter
//   Fifo_Count    out  receive FIFO occupancy
//   Overflow      out  sticky: a received byte was dropped on a full FIFO
//   Busy          out  a reply frame is in progress

module uart_echo_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 254,
  parameter int HEX_MODE   = 0,
  parameter int CRLF       = 0
) (
  input  logic                          Uart_CLK,
  input  logic                          Sys_RST,
  input  logic [7:0]                    Rx_Data,
  input  logic                          Rx_Rdsig,
  input  logic                          Rx_DataError,
  input  logic                          Rx_FrameError,
  input  logic                          Tx_Idle,
  output logic [7:0]                    Tx_Data,
  output logic                          Tx_Wrsig,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
  output logic                          Overflow,
  output logic                          Busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [7:0]    GAP_MAX  = 8'(GAP_CYCLES - 1);
  localparam bit            HEX      = (HEX_MODE != 0);
  localparam bit            USE_LF   = (CRLF != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PREFIX = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_ERR    = 3'd3;
  localparam logic [2:0] S_CR     = 3'd4;
  localparam logic [2:0] S_LF     = 3'd5;

  function automatic logic [7:0] prefix_char(input logic [2:0] i);
    case (i)
      3'd0:    prefix_char = 8'h52;
      3'd1:    prefix_char = 8'h65;
      3'd2:    prefix_char = 8'h74;
      3'd3:    prefix_char = 8'h75;
      3'd4:    prefix_char = 8'h72;
      3'd5:    prefix_char = 8'h6E;
      3'd6:    prefix_char = 8'h3A;
      default: prefix_char = 8'h20;
    endcase
  endfunction

  function automatic logic [7:0] err_char(input logic [2:0] i);
    case (i)
      3'd0:    err_char = 8'h45;
      3'd1:    err_char = 8'h72;
      3'd2:    err_char = 8'h72;
      3'd3:    err_char = 8'h6F;
      3'd4:    err_char = 8'h72;
      default: err_char = 8'h21;
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  logic          rdsig_q;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic [7:0]    gap_q;
  logic [2:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    frame_q, frame_d;
  logic [7:0]    txd_q, char_d;
  logic          wrsig_q, emit;

  logic       push, pop, push_ok, fifo_full, fifo_empty, can_emit;
  logic [8:0] head;

  assign push       = rdsig_q & ~Rx_Rdsig;
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;
  // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts.
  assign push_ok    = push & (~fifo_full | pop);
  assign head       = mem[rd_ptr_q];
  assign can_emit   = (gap_q == GAP_MAX) & Tx_Idle;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // The error bit only selects the reply branch; the frame register keeps the data byte.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    emit    = 1'b0;
    char_d  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          frame_d = head[7:0];
          idx_d   = 3'd0;
          state_d = head[8] ? S_ERR : S_PREFIX;
        end
      end
      S_PREFIX: begin
        char_d = prefix_char(idx_q);
        if (can_emit) begin
          emit = 1'b1;
          if (idx_q == 3'd7) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_DATA: begin
        if (HEX) char_d = idx_q[0] ? hex_char(frame_q[3:0]) : hex_char(frame_q[7:4]);
        else     char_d = frame_q;
        if (can_emit) begin
          emit = 1'b1;
          if (!HEX || idx_q[0]) state_d = S_CR;
          else                  idx_d   = idx_q + 3'd1;
        end
      end
      S_ERR: begin
        char_d = err_char(idx_q);
        if (can_emit) begin
          emit = 1'b1;
          if (idx_q == 3'd5) state_d = S_CR;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_CR: begin
        char_d = 8'h0D;
        if (can_emit) begin
          emit    = 1'b1;
          state_d = USE_LF ? S_LF : S_IDLE;
        end
      end
      S_LF: begin
        char_d = 8'h0A;
        if (can_emit) begin
          emit    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Contents need no reset: emptiness is tracked by pointers and count alone.
  always_ff @(posedge Uart_CLK) begin
    if (push_ok) mem[wr_ptr_q] <= {Rx_DataError | Rx_FrameError, Rx_Data};
  end

  always_ff @(posedge Uart_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      rdsig_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      gap_q    <= GAP_MAX;
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      frame_q  <= 8'h00;
      txd_q    <= 8'h00;
      wrsig_q  <= 1'b0;
    end else begin
      rdsig_q <= Rx_Rdsig;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
      // Cleared on the same edge that raises Tx_Wrsig, so strobes are GAP_CYCLES apart.
      if (emit)                  gap_q <= 8'h00;
      else if (gap_q != GAP_MAX) gap_q <= gap_q + 8'd1;
      if (emit) txd_q <= char_d;
      wrsig_q <= emit;
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  assign Tx_Data    = txd_q;
  assign Tx_Wrsig   = wrsig_q;
  assign Fifo_Count = count_q;
  assign Overflow   = ovf_q;
  assign Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb/tb_uart_echo_ctrl.sv - self-checking bench for uart_echo_ctrl across three configurations

module tb_uart_echo_ctrl;

  localparam int DEPTH_K [3] = '{8, 4, 8};
  localparam int GAP_K   [3] = '{254, 4, 4};
  localparam int HEX_K   [3] = '{0, 1, 0};
  localparam int CRLF_K  [3] = '{0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_rdsig, rx_perr, rx_ferr, tx_idle;
  logic [7:0] txd  [3];
  logic       wr   [3];
  logic       ovf  [3];
  logic       busy [3];
  logic [3:0] cnt_a, cnt_c;
  logic [2:0] cnt_b;
  logic [3:0] cnt  [3];

  assign cnt[0] = cnt_a;
  assign cnt[1] = {1'b0, cnt_b};
  assign cnt[2] = cnt_c;

  uart_echo_ctrl #(.FIFO_DEPTH(DEPTH_K[0]), .GAP_CYCLES(GAP_K[0]), .HEX_MODE(HEX_K[0]), .CRLF(CRLF_K[0])) dut_a (
    .Uart_CLK(clk), .Sys_RST(rst_n), .Rx_Data(rx_data), .Rx_Rdsig(rx_rdsig),
    .Rx_DataError(rx_perr), .Rx_FrameError(rx_ferr), .Tx_Idle(tx_idle),
    .Tx_Data(txd[0]), .Tx_Wrsig(wr[0]), .Fifo_Count(cnt_a), .Overflow(ovf[0]), .Busy(busy[0]));

  uart_echo_ctrl #(.FIFO_DEPTH(DEPTH_K[1]), .GAP_CYCLES(GAP_K[1]), .HEX_MODE(HEX_K[1]), .CRLF(CRLF_K[1])) dut_b (
    .Uart_CLK(clk), .Sys_RST(rst_n), .Rx_Data(rx_data), .Rx_Rdsig(rx_rdsig),
    .Rx_DataError(rx_perr), .Rx_FrameError(rx_ferr), .Tx_Idle(tx_idle),
    .Tx_Data(txd[1]), .Tx_Wrsig(wr[1]), .Fifo_Count(cnt_b), .Overflow(ovf[1]), .Busy(busy[1]));

  uart_echo_ctrl #(.FIFO_DEPTH(DEPTH_K[2]), .GAP_CYCLES(GAP_K[2]), .HEX_MODE(HEX_K[2]), .CRLF(CRLF_K[2])) dut_c (
    .Uart_CLK(clk), .Sys_RST(rst_n), .Rx_Data(rx_data), .Rx_Rdsig(rx_rdsig),
    .Rx_DataError(rx_perr), .Rx_FrameError(rx_ferr), .Tx_Idle(tx_idle),
    .Tx_Data(txd[2]), .Tx_Wrsig(wr[2]), .Fifo_Count(cnt_c), .Overflow(ovf[2]), .Busy(busy[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: written by the stimulus process
  logic [7:0] exp_mem  [3][0:511];
  int         exp_wr   [3] = '{0, 0, 0};
  int         flen_mem [3][0:63];
  int         fl_wr    [3] = '{0, 0, 0};
  int         pushed   [3] = '{0, 0, 0};
  bit         ovf_exp  [3] = '{0, 0, 0};
  // Model state: written by the compare process
  int         exp_rd   [3] = '{0, 0, 0};
  int         fl_rd    [3] = '{0, 0, 0};
  int         done_n   [3] = '{0, 0, 0};
  int         sent     [3] = '{0, 0, 0};
  int         last_s   [3] = '{-100000, -100000, -100000};
  logic [7:0] tx_last  [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] log_d    [3][0:511];
  int         log_c    [3][0:511];
  int         log_n    [3] = '{0, 0, 0};
  bit         idle_prev = 1'b1;
  int         n_chk = 0;
  int         n_fail = 0;

  // Directed expectations posted by the stimulus process, evaluated by the compare process
  string       req_nm  [0:255];
  int          req_k   [0:255];
  logic [31:0] req_act [0:255];
  logic [31:0] req_exp [0:255];
  int          req_wr = 0;
  int          req_rd = 0;

  string s_ret = "Return: ";
  string s_err = "Error!";
  string hexd  = "0123456789ABCDEF";

  logic [7:0] lit1 [10] = '{8'h52, 8'h65, 8'h74, 8'h75, 8'h72, 8'h6E, 8'h3A, 8'h20, 8'h41, 8'h0D};
  logic [7:0] lit2 [12] = '{8'h52, 8'h65, 8'h74, 8'h75, 8'h72, 8'h6E, 8'h3A, 8'h20, 8'h33, 8'h43, 8'h0D, 8'h0A};
  logic [7:0] lit3 [7]  = '{8'h45, 8'h72, 8'h72, 8'h6F, 8'h72, 8'h21, 8'h0D};

  task automatic ck(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (req_rd < req_wr) begin
        ck(req_nm[req_rd], req_k[req_rd], req_act[req_rd], req_exp[req_rd]);
        req_rd++;
      end
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          exp_rd[k]  = exp_wr[k];
          fl_rd[k]   = fl_wr[k];
          done_n[k]  = pushed[k];
          sent[k]    = 0;
          last_s[k]  = -100000;
          tx_last[k] = 8'h00;
        end else if (wr[k]) begin
          log_d[k][log_n[k]] = txd[k];
          log_c[k][log_n[k]] = cyc;
          log_n[k]++;
          if (exp_rd[k] == exp_wr[k]) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected strobe dut%0d: got 0x%0h required no strobe", k, txd[k]);
          end else begin
            ck("strobe data", k, txd[k], exp_mem[k][exp_rd[k]]);
            exp_rd[k]++;
          end
          n_chk++;
          if (cyc - last_s[k] < GAP_K[k]) begin
            n_fail++;
            $display("FAIL strobe spacing dut%0d: got %0d cycles required >= %0d", k, cyc - last_s[k], GAP_K[k]);
          end
          ck("tx_idle before strobe", k, idle_prev, 1);
          last_s[k]  = cyc;
          tx_last[k] = txd[k];
          sent[k]++;
          if (fl_rd[k] < fl_wr[k] && sent[k] == flen_mem[k][fl_rd[k]]) begin
            ck("busy at last strobe", k, busy[k], 0);
            fl_rd[k]++;
            sent[k] = 0;
            done_n[k]++;
          end else begin
            ck("busy mid frame", k, busy[k], 1);
          end
        end else begin
          ck("tx_data held", k, txd[k], tx_last[k]);
          if (sent[k] > 0) begin
            ck("busy mid frame", k, busy[k], 1);
            ck("strobe due", k, (cyc - last_s[k] >= GAP_K[k]) && idle_prev, 0);
          end
        end
      end
      idle_prev = tx_idle;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    req_nm[req_wr]  = nm;
    req_k[req_wr]   = k;
    req_act[req_wr] = act;
    req_exp[req_wr] = exp;
    req_wr++;
  endtask

  task automatic put_exp(input int k, input logic [7:0] b);
    exp_mem[k][exp_wr[k]] = b;
    exp_wr[k]++;
  endtask

  // Reply text built from the frame rules; capacity is FIFO plus the frame in progress.
  task automatic model_rx(input logic [7:0] d, input bit err);
    string s;
    int    start;
    for (int k = 0; k < 3; k++) begin
      if (pushed[k] - done_n[k] >= DEPTH_K[k] + 1) begin
        ovf_exp[k] = 1'b1;
      end else begin
        start = exp_wr[k];
        s = err ? s_err : s_ret;
        for (int i = 0; i < s.len(); i++) put_exp(k, s[i]);
        if (!err) begin
          if (HEX_K[k] != 0) begin
            put_exp(k, hexd[int'(d[7:4])]);
            put_exp(k, hexd[int'(d[3:0])]);
          end else begin
            put_exp(k, d);
          end
        end
        put_exp(k, 8'h0D);
        if (CRLF_K[k] != 0) put_exp(k, 8'h0A);
        flen_mem[k][fl_wr[k]] = exp_wr[k] - start;
        fl_wr[k]++;
        pushed[k]++;
      end
    end
  endtask

  task automatic rx(input logic [7:0] d, input bit perr, input bit ferr);
    rx_data  = d;
    rx_rdsig = 1'b1;
    repeat (3) tick;
    rx_perr  = perr;
    rx_ferr  = ferr;
    rx_rdsig = 1'b0;
    model_rx(d, perr | ferr);
    tick;
    rx_perr = 1'b0;
    rx_ferr = 1'b0;
    tick;
  endtask

  task automatic drain(input int budget);
    int w;
    w = 0;
    while (w < budget && !(exp_rd[0] == exp_wr[0] && exp_rd[1] == exp_wr[1] && exp_rd[2] == exp_wr[2])) begin
      tick;
      w++;
    end
    if (w >= budget) req("drain timeout", 0, 1, 0);
    repeat (4) tick;
  endtask

  int s0, s1, s2, sb, sc, t_rise, w;

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_rdsig = 1'b0;
    rx_perr  = 1'b0;
    rx_ferr  = 1'b0;
    tx_idle  = 1'b1;
    repeat (3) tick;
    for (int k = 0; k < 3; k++) begin
      req("reset tx_data", k, txd[k], 0);
      req("reset tx_wrsig", k, wr[k], 0);
      req("reset fifo_count", k, cnt[k], 0);
      req("reset overflow", k, ovf[k], 0);
      req("reset busy", k, busy[k], 0);
    end
    rst_n = 1'b1;
    repeat (2) tick;

    // Raw echo of 'A' on the default configuration
    s0 = log_n[0];
    rx(8'h41, 1'b0, 1'b0);
    drain(6000);
    req("t1 frame length", 0, log_n[0] - s0, 10);
    for (int i = 0; i < 10; i++) req("t1 byte", 0, log_d[0][s0 + i], lit1[i]);
    for (int i = 1; i < 10; i++) req("t1 spacing", 0, log_c[0][s0 + i] - log_c[0][s0 + i - 1], 254);
    req("t1 busy after CR", 0, busy[0], 0);

    // Hex + CRLF echo of 0x3C
    s1 = log_n[1];
    rx(8'h3C, 1'b0, 1'b0);
    drain(6000);
    req("t2 frame length", 1, log_n[1] - s1, 12);
    for (int i = 0; i < 12; i++) req("t2 byte", 1, log_d[1][s1 + i], lit2[i]);
    for (int i = 1; i < 12; i++) req("t2 spacing", 1, log_c[1][s1 + i] - log_c[1][s1 + i - 1], 4);

    // Frame error reply
    s2 = log_n[2];
    rx(8'hC3, 1'b0, 1'b1);
    drain(6000);
    req("t3 frame length", 2, log_n[2] - s2, 7);
    for (int i = 0; i < 7; i++) req("t3 byte", 2, log_d[2][s2 + i], lit3[i]);

    // Overflow with the transmitter held off
    tx_idle = 1'b0;
    tick;
    rx(8'h10, 1'b0, 1'b0);
    rx(8'h21, 1'b0, 1'b0);
    rx(8'h32, 1'b1, 1'b0);
    rx(8'h43, 1'b0, 1'b0);
    rx(8'h54, 1'b0, 1'b0);
    rx(8'h65, 1'b0, 1'b0);
    repeat (5) tick;
    req("t4 fifo_count depth4", 1, cnt[1], 4);
    req("t4 overflow depth4", 1, ovf[1], 1);
    req("t4 fifo_count depth8", 0, cnt[0], 5);
    req("t4 overflow depth8", 0, ovf[0], 0);
    for (int k = 0; k < 3; k++) req("t4 fifo_count model", k, cnt[k], pushed[k] - done_n[k] - 1);
    sb = log_n[1];
    sc = log_n[2];
    tx_idle = 1'b1;
    drain(20000);
    req("t4 strobes depth4", 1, log_n[1] - sb, 56);
    req("t4 strobes depth8", 2, log_n[2] - sc, 57);
    req("t4 last frame hi", 1, log_d[1][sb + 52], 8'h35);
    req("t4 last frame lo", 1, log_d[1][sb + 53], 8'h34);

    // Transmitter stall mid-prefix
    s1 = log_n[1];
    rx(8'h7E, 1'b0, 1'b0);
    w = 0;
    while (log_n[1] - s1 < 3 && w < 300) begin
      tick;
      w++;
    end
    if (w >= 300) req("t5 wait timeout", 1, 1, 0);
    tx_idle = 1'b0;
    repeat (20) tick;
    tx_idle = 1'b1;
    t_rise  = cyc;
    drain(6000);
    req("t5 resume cycle", 1, log_c[1][s1 + 3] - t_rise, 1);
    req("t5 frame length", 1, log_n[1] - s1, 12);

    // Reset while sending the data character
    s1 = log_n[1];
    rx(8'h5A, 1'b0, 1'b0);
    w = 0;
    while (log_n[1] - s1 < 8 && w < 300) begin
      tick;
      w++;
    end
    if (w >= 300) req("t6 wait timeout", 1, 1, 0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      req("t6 reset tx_wrsig", k, wr[k], 0);
      req("t6 reset busy", k, busy[k], 0);
      req("t6 reset fifo_count", k, cnt[k], 0);
    end
    repeat (2) tick;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) ovf_exp[k] = 1'b0;
    tick;
    s1 = log_n[1];
    rx(8'h9F, 1'b0, 1'b0);
    drain(6000);
    req("t6 frame length", 1, log_n[1] - s1, 12);
    req("t6 first byte", 1, log_d[1][s1], 8'h52);
    req("t6 hex hi", 1, log_d[1][s1 + 8], 8'h39);
    req("t6 hex lo", 1, log_d[1][s1 + 9], 8'h46);

    for (int k = 0; k < 3; k++) req("final overflow", k, ovf[k], ovf_exp[k]);
    repeat (3) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
